// File: rtl/alu_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_scheduler
// Purpose : Round-robin, RAW-aware issue of NUM_REQ warps onto one shared,
//           fixed-latency ALU (execute stage 1, writeback stage 2).
//           Optional macro ALU_WB_BYPASS_EN: writeback forwarding, so only
//           stage-1 matches block issue.
// Revision: 1.0
// ============================================================================
module alu_issue_scheduler #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_instr_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic                     alu_en_i,
    output logic                     alu_valid_o,
    output logic [WIDTH-1:0]         alu_instr_o,
    output logic [ID_W-1:0]          alu_req_id_o,
    output logic                     wb_valid_o,
    output logic [5:0]               wb_dest_o,
    output logic [ID_W-1:0]          wb_req_id_o,
    output logic                     hazard_stall_o
);

    logic               v1_q, v1_d;
    logic [WIDTH-1:0]   instr1_q, instr1_d;
    logic [ID_W-1:0]    id1_q, id1_d;
    logic [5:0]         dest1_q, dest1_d;
    logic               v2_q;
    logic [5:0]         dest2_q;
    logic [ID_W-1:0]    id2_q;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] hazard_w;
    logic [NUM_REQ-1:0] eligible_w;
    logic [NUM_REQ-1:0] grant_w;
    logic               grant_found_w;
    logic [ID_W-1:0]    grant_id_w;
    logic [ID_W-1:0]    idx_w;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [5:0] src1_w;
            logic [5:0] src2_w;
            logic       s1_hit_w;
            logic       s2_hit_w;

            assign src1_w   = {1'b0, req_instr_i[gi*WIDTH+14 +: 5]};
            assign src2_w   = {1'b1, req_instr_i[gi*WIDTH+19 +: 5]};
            // Only the requester's own in-flight results can conflict: banks are private.
            assign s1_hit_w = v1_q && (id1_q == ID_W'(gi)) &&
                              ((dest1_q == src1_w) || (dest1_q == src2_w));
`ifdef ALU_WB_BYPASS_EN
            assign s2_hit_w = 1'b0;
`else
            assign s2_hit_w = v2_q && (id2_q == ID_W'(gi)) &&
                              ((dest2_q == src1_w) || (dest2_q == src2_w));
`endif
            assign hazard_w[gi] = s1_hit_w || s2_hit_w;
        end
    endgenerate

    // Reset gating keeps the combinational grant silent while rst_ni is low.
    assign eligible_w = req_valid_i & ~hazard_w & {NUM_REQ{alu_en_i & rst_ni}};

    always_comb begin
        grant_found_w = 1'b0;
        grant_id_w    = rr_ptr_q;
        idx_w         = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx_w = rr_ptr_q + ID_W'(off);
            if (!grant_found_w && eligible_w[idx_w]) begin
                grant_found_w = 1'b1;
                grant_id_w    = idx_w;
            end
        end
    end

    assign grant_w = grant_found_w ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_w)
                                   : '0;

    always_comb begin
        v1_d     = grant_found_w;
        instr1_d = instr1_q;
        id1_d    = id1_q;
        dest1_d  = dest1_q;
        rr_ptr_d = rr_ptr_q;
        if (grant_found_w) begin
            instr1_d = req_instr_i[grant_id_w*WIDTH +: WIDTH];
            id1_d    = grant_id_w;
            dest1_d  = instr1_d[14:9];
            rr_ptr_d = grant_id_w + ID_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q     <= 1'b0;
            instr1_q <= '0;
            id1_q    <= '0;
            dest1_q  <= '0;
            v2_q     <= 1'b0;
            dest2_q  <= '0;
            id2_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            v1_q     <= v1_d;
            instr1_q <= instr1_d;
            id1_q    <= id1_d;
            dest1_q  <= dest1_d;
            v2_q     <= v1_q;
            dest2_q  <= dest1_q;
            id2_q    <= id1_q;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign req_ready_o    = grant_w;
    assign alu_valid_o    = v1_q;
    assign alu_instr_o    = instr1_q;
    assign alu_req_id_o   = id1_q;
    assign wb_valid_o     = v2_q;
    assign wb_dest_o      = dest2_q;
    assign wb_req_id_o    = id2_q;
    assign hazard_stall_o = |(req_valid_i & hazard_w);

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_alu_issue_scheduler
// Purpose : Vector table, corner sequences and randomized model comparison
//           for alu_issue_scheduler (NUM_REQ=4, WIDTH=32).
// Revision: 1.0
// ============================================================================
module tb_alu_issue_scheduler;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
`ifdef ALU_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                     clk_i = 1'b0;
    logic                     rst_ni = 1'b0;
    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ*WIDTH-1:0] req_instr_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic                     alu_en_i;
    logic                     alu_valid_o;
    logic [WIDTH-1:0]         alu_instr_o;
    logic [ID_W-1:0]          alu_req_id_o;
    logic                     wb_valid_o;
    logic [5:0]               wb_dest_o;
    logic [ID_W-1:0]          wb_req_id_o;
    logic                     hazard_stall_o;

    alu_issue_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_instr_i    (req_instr_i),
        .req_ready_o    (req_ready_o),
        .alu_en_i       (alu_en_i),
        .alu_valid_o    (alu_valid_o),
        .alu_instr_o    (alu_instr_o),
        .alu_req_id_o   (alu_req_id_o),
        .wb_valid_o     (wb_valid_o),
        .wb_dest_o      (wb_dest_o),
        .wb_req_id_o    (wb_req_id_o),
        .hazard_stall_o (hazard_stall_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] dlow, input logic [4:0] s1, input logic [4:0] s2);
        logic [31:0] r;
        r        = '0;
        r[13:9]  = dlow;
        r[18:14] = s1;
        r[23:19] = s2;
        return r;
    endfunction

    function automatic logic [5:0] f_dest(input logic [31:0] ins);
        return ins[14:9];
    endfunction
    function automatic logic [5:0] f_src1(input logic [31:0] ins);
        return {1'b0, ins[18:14]};
    endfunction
    function automatic logic [5:0] f_src2(input logic [31:0] ins);
        return {1'b1, ins[23:19]};
    endfunction

    function automatic int oh2idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return 0;
    endfunction

    typedef struct {
        logic [3:0]  valid;
        logic        en;
        logic [31:0] instr0;
        logic [31:0] instr1;
        logic [3:0]  exp_ready;
        logic        exp_stall;
    } vec_t;

    function automatic vec_t row(input logic [3:0] v, input logic en, input logic [31:0] i0,
                                 input logic [31:0] i1, input logic [3:0] rdy, input logic stl);
        vec_t r;
        r.valid = v; r.en = en; r.instr0 = i0; r.instr1 = i1; r.exp_ready = rdy; r.exp_stall = stl;
        return r;
    endfunction

    // Reference model: history of the last two issue slots (index 1 = newest = execute).
    typedef struct {
        bit          v;
        logic [31:0] instr;
        int          id;
    } ent_t;
    ent_t mq[$];
    int   rr;

    function automatic bit m_hazard(input int i, input logic [31:0] ins);
        for (int age = 0; age < 2; age++) begin
            ent_t e;
            e = mq[1-age];
            if (age == 1 && BYP) continue;
            if (e.v && e.id == i &&
                (f_dest(e.instr) == f_src1(ins) || f_dest(e.instr) == f_src2(ins)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive(input logic [3:0] v, input logic en, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [31:0] i2, input logic [31:0] i3);
        req_valid_i = v;
        alu_en_i    = en;
        req_instr_i = {i3, i2, i1, i0};
    endtask

    vec_t        tbl[17];
    logic [31:0] I0, I1;
    logic [31:0] rin[4];
    logic [3:0]  rv, exp_rdy;
    logic        ren, exp_stl;
    bit          hz[4];
    int          k;

    initial begin
        I0 = mk(5'd5, 5'd0, 5'd0);   // dest 6'h05, reads 6'h00 / 6'h20
        I1 = mk(5'd7, 5'd5, 5'd0);   // reads src1 = 5, dest 6'h27

        tbl[0]  = row(4'hF, 1, I0, I0, 4'b0001, 0);
        tbl[1]  = row(4'hF, 1, I0, I0, 4'b0010, 0);
        tbl[2]  = row(4'hF, 1, I0, I0, 4'b0100, 0);
        tbl[3]  = row(4'hF, 1, I0, I0, 4'b1000, 0);
        tbl[4]  = row(4'hF, 1, I0, I0, 4'b0001, 0);
        tbl[5]  = row(4'h0, 1, I0, I0, 4'b0000, 0);
        tbl[6]  = row(4'h0, 1, I0, I0, 4'b0000, 0);
        tbl[7]  = row(4'h1, 1, I0, I0, 4'b0001, 0);
        tbl[8]  = row(4'h1, 1, I1, I0, 4'b0000, 1);
        tbl[9]  = row(4'h1, 1, I1, I0, BYP ? 4'b0001 : 4'b0000, !BYP);
        tbl[10] = row(4'h1, 1, I1, I0, 4'b0001, 0);
        tbl[11] = row(4'h1, 1, I0, I0, 4'b0001, 0);
        tbl[12] = row(4'h2, 1, I0, I1, 4'b0010, 0);
        tbl[13] = row(4'hF, 0, I0, I0, 4'b0000, 0);
        tbl[14] = row(4'hF, 0, I0, I0, 4'b0000, 0);
        tbl[15] = row(4'hF, 0, I0, I0, 4'b0000, 0);
        tbl[16] = row(4'hF, 1, I0, I0, 4'b0100, 0);

        // Reset held with every requester valid.
        drive(4'hF, 1'b1, I0, I0, I0, I0);
        repeat (2) @(negedge clk_i);
        check("rst_ready", 64'(req_ready_o), 64'(0));
        check("rst_alu_valid", 64'(alu_valid_o), 64'(0));
        check("rst_wb_valid", 64'(wb_valid_o), 64'(0));
        check("rst_stall", 64'(hazard_stall_o), 64'(0));
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        for (int r = 0; r < 17; r++) begin
            drive(tbl[r].valid, tbl[r].en, tbl[r].instr0, tbl[r].instr1, I0, I0);
            @(negedge clk_i);
            check($sformatf("tbl%0d_ready", r), 64'(req_ready_o), 64'(tbl[r].exp_ready));
            check($sformatf("tbl%0d_stall", r), 64'(hazard_stall_o), 64'(tbl[r].exp_stall));
            if (r > 0) begin
                check($sformatf("tbl%0d_alu_valid", r), 64'(alu_valid_o), 64'(tbl[r-1].exp_ready != 0));
                if (tbl[r-1].exp_ready != 0) begin
                    int      g;
                    logic [31:0] gi;
                    g  = oh2idx(tbl[r-1].exp_ready);
                    gi = (g == 0) ? tbl[r-1].instr0 : (g == 1) ? tbl[r-1].instr1 : I0;
                    check($sformatf("tbl%0d_alu_id", r), 64'(alu_req_id_o), 64'(g));
                    check($sformatf("tbl%0d_alu_instr", r), 64'(alu_instr_o), 64'(gi));
                end
            end
            if (r > 1)
                check($sformatf("tbl%0d_wb_valid", r), 64'(wb_valid_o), 64'(tbl[r-2].exp_ready != 0));
            @(posedge clk_i); #1;
        end

        // Asynchronous reset between edges with both stages occupied and rr_ptr != 0.
        drive(4'b0011, 1'b1, I0, I0, I0, I0);
        @(negedge clk_i);
        check("mid_ready_pre", 64'(req_ready_o), 64'(4'b0001));
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("mid_alu_valid_pre", 64'(alu_valid_o), 64'(1));
        check("mid_wb_valid_pre", 64'(wb_valid_o), 64'(1));
        check("mid_ready_rr1", 64'(req_ready_o), 64'(4'b0010));
        #1 rst_ni = 1'b0;
        #1;
        check("mid_alu_valid_rst", 64'(alu_valid_o), 64'(0));
        check("mid_wb_valid_rst", 64'(wb_valid_o), 64'(0));
        check("mid_ready_rst", 64'(req_ready_o), 64'(0));
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("mid_ready_rr0", 64'(req_ready_o), 64'(4'b0001));
        check("mid_alu_valid_post", 64'(alu_valid_o), 64'(0));

        // Randomized traffic against the reference model, from a fresh reset.
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        mq.delete();
        mq.push_back('{v: 1'b0, instr: '0, id: 0});
        mq.push_back('{v: 1'b0, instr: '0, id: 0});
        rr = 0;

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                rin[i]        = $urandom;
                rin[i][13:9]  = 5'($urandom_range(0, 3));
                rin[i][18:14] = 5'($urandom_range(0, 3));
                rin[i][23:19] = 5'($urandom_range(0, 3));
            end
            rv  = 4'($urandom_range(0, 15));
            ren = ($urandom_range(0, 9) != 0);
            drive(rv, ren, rin[0], rin[1], rin[2], rin[3]);
            @(negedge clk_i);

            exp_stl = 1'b0;
            for (int i = 0; i < 4; i++) begin
                hz[i] = m_hazard(i, rin[i]);
                if (rv[i] && hz[i]) exp_stl = 1'b1;
            end
            k = -1;
            if (ren)
                for (int o = 0; o < 4; o++) begin
                    int j;
                    j = (rr + o) % 4;
                    if (k < 0 && rv[j] && !hz[j]) k = j;
                end
            exp_rdy = (k >= 0) ? (4'b0001 << k) : 4'b0000;

            check("rnd_ready", 64'(req_ready_o), 64'(exp_rdy));
            check("rnd_stall", 64'(hazard_stall_o), 64'(exp_stl));
            check("rnd_alu_valid", 64'(alu_valid_o), 64'(mq[1].v));
            check("rnd_wb_valid", 64'(wb_valid_o), 64'(mq[0].v));
            if (mq[1].v) begin
                check("rnd_alu_instr", 64'(alu_instr_o), 64'(mq[1].instr));
                check("rnd_alu_id", 64'(alu_req_id_o), 64'(mq[1].id));
            end
            if (mq[0].v) begin
                check("rnd_wb_dest", 64'(wb_dest_o), 64'(f_dest(mq[0].instr)));
                check("rnd_wb_id", 64'(wb_req_id_o), 64'(mq[0].id));
            end

            @(posedge clk_i);
            void'(mq.pop_front());
            if (k >= 0) begin
                mq.push_back('{v: 1'b1, instr: rin[k], id: k});
                rr = (k + 1) % 4;
            end else begin
                mq.push_back('{v: 1'b0, instr: '0, id: 0});
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
